// File: rtl/astro_pkg.sv
// Shared AstroGenius definitions: shot opcodes, record widths, mover state codes
// and the per-axis direction decode used by the movement calculators.
package astro_pkg;

   localparam int OPCODE_W      = 3;
   localparam int COORD_W_DFLT  = 8;
   localparam int ESTADO_W      = 3;

   // Opcode names: DIR/ESQ = +x/-x, BAIXO/CIMA = +y/-y
   localparam logic [OPCODE_W-1:0] OP_DIR_DIR       = 3'b000;
   localparam logic [OPCODE_W-1:0] OP_DIR_ESQ       = 3'b001;
   localparam logic [OPCODE_W-1:0] OP_DIR_BAIXO     = 3'b010;
   localparam logic [OPCODE_W-1:0] OP_DIR_CIMA      = 3'b011;
   localparam logic [OPCODE_W-1:0] OP_DIR_DIR_BAIXO = 3'b100;
   localparam logic [OPCODE_W-1:0] OP_DIR_DIR_CIMA  = 3'b101;
   localparam logic [OPCODE_W-1:0] OP_DIR_ESQ_BAIXO = 3'b110;
   localparam logic [OPCODE_W-1:0] OP_DIR_ESQ_CIMA  = 3'b111;

   typedef enum logic [ESTADO_W-1:0] {
      ST_ESPERA   = 3'd0,
      ST_LEITURA  = 3'd1,
      ST_AVALIA   = 3'd2,
      ST_ESCREVE  = 3'd3,
      ST_SINALIZA = 3'd4
   } estado_t;

   typedef enum logic [1:0] {
      MV_ZERO = 2'd0,
      MV_POS  = 2'd1,
      MV_NEG  = 2'd2
   } mov_t;

   function automatic mov_t mov_x(input logic [OPCODE_W-1:0] op);
      mov_t m;
      case (op)
         OP_DIR_DIR, OP_DIR_DIR_BAIXO, OP_DIR_DIR_CIMA: m = MV_POS;
         OP_DIR_ESQ, OP_DIR_ESQ_BAIXO, OP_DIR_ESQ_CIMA: m = MV_NEG;
         default:                                      m = MV_ZERO;
      endcase
      return m;
   endfunction

   function automatic mov_t mov_y(input logic [OPCODE_W-1:0] op);
      mov_t m;
      case (op)
         OP_DIR_BAIXO, OP_DIR_DIR_BAIXO, OP_DIR_ESQ_BAIXO: m = MV_POS;
         OP_DIR_CIMA, OP_DIR_DIR_CIMA, OP_DIR_ESQ_CIMA:    m = MV_NEG;
         default:                                         m = MV_ZERO;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/uc_move_tiros_n_if.sv
// Shot-memory port: address, synchronous read data and write strobe/data.
interface uc_move_tiros_n_if
   import astro_pkg::*;
#(
   parameter int AW      = 3,
   parameter int COORD_W = COORD_W_DFLT
);
   logic [AW-1:0]       mem_addr;
   logic                mem_rd_loaded;
   logic [OPCODE_W-1:0] mem_rd_opcode;
   logic [COORD_W-1:0]  mem_rd_x;
   logic [COORD_W-1:0]  mem_rd_y;
   logic                mem_we;
   logic                mem_wr_loaded;
   logic [COORD_W-1:0]  mem_wr_x;
   logic [COORD_W-1:0]  mem_wr_y;

   modport master (
      output mem_addr, mem_we, mem_wr_loaded, mem_wr_x, mem_wr_y,
      input  mem_rd_loaded, mem_rd_opcode, mem_rd_x, mem_rd_y
   );

   modport slave (
      input  mem_addr, mem_we, mem_wr_loaded, mem_wr_x, mem_wr_y,
      output mem_rd_loaded, mem_rd_opcode, mem_rd_x, mem_rd_y
   );
endinterface

// File: rtl/calc_pos_tiro.sv
// Combinational next-position and off-screen test for one moving object.
// Exit tests use one extra bit so nothing wraps near the coordinate limits.
module calc_pos_tiro
   import astro_pkg::*;
#(
   parameter int COORD_W = COORD_W_DFLT,
   parameter int X_MIN   = 0,
   parameter int X_MAX   = 159,
   parameter int Y_MIN   = 0,
   parameter int Y_MAX   = 119,
   parameter int STEP    = 1
)(
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic [COORD_W-1:0]  i_x,
   input  logic [COORD_W-1:0]  i_y,
   output logic [COORD_W-1:0]  o_new_x,
   output logic [COORD_W-1:0]  o_new_y,
   output logic                o_sai_tela
);
   localparam logic [COORD_W:0]   L_STEP    = (COORD_W+1)'(STEP);
   localparam logic [COORD_W-1:0] L_STEP_C  = COORD_W'(STEP);
   localparam logic [COORD_W:0]   L_X_MAX   = (COORD_W+1)'(X_MAX);
   localparam logic [COORD_W:0]   L_Y_MAX   = (COORD_W+1)'(Y_MAX);
   localparam logic [COORD_W:0]   L_X_LIMN  = (COORD_W+1)'(X_MIN + STEP);
   localparam logic [COORD_W:0]   L_Y_LIMN  = (COORD_W+1)'(Y_MIN + STEP);

   mov_t             w_mx;
   mov_t             w_my;
   logic [COORD_W:0] w_x_ext;
   logic [COORD_W:0] w_y_ext;
   logic             w_sai_x;
   logic             w_sai_y;

   always_comb begin
      w_mx    = mov_x(i_opcode);
      w_my    = mov_y(i_opcode);
      w_x_ext = {1'b0, i_x};
      w_y_ext = {1'b0, i_y};
      w_sai_x = 1'b0;
      w_sai_y = 1'b0;
      o_new_x = i_x;
      o_new_y = i_y;

      case (w_mx)
         MV_POS: begin
            w_sai_x = (w_x_ext + L_STEP) > L_X_MAX;
            o_new_x = i_x + L_STEP_C;
         end
         MV_NEG: begin
            w_sai_x = w_x_ext < L_X_LIMN;
            o_new_x = i_x - L_STEP_C;
         end
         default: ;
      endcase

      case (w_my)
         MV_POS: begin
            w_sai_y = (w_y_ext + L_STEP) > L_Y_MAX;
            o_new_y = i_y + L_STEP_C;
         end
         MV_NEG: begin
            w_sai_y = w_y_ext < L_Y_LIMN;
            o_new_y = i_y - L_STEP_C;
         end
         default: ;
      endcase

      o_sai_tela = w_sai_x | w_sai_y;
   end

endmodule

// File: rtl/uc_move_tiros_n.sv
// Shot mover: one pass over the shot memory per start request, unloading
// shots that would leave the screen and stepping the rest.
//
// state    | meaning
// ESPERA   | idle, waiting for iniciar
// LEITURA  | present index on mem_addr
// AVALIA   | read data valid, compute move or exit
// ESCREVE  | write the entry back
// SINALIZA | one-cycle completion pulse
module uc_move_tiros_n
   import astro_pkg::*;
#(
   parameter int N_TIROS = 8,
   parameter int COORD_W = COORD_W_DFLT,
   parameter int X_MIN   = 0,
   parameter int X_MAX   = 159,
   parameter int Y_MIN   = 0,
   parameter int Y_MAX   = 119,
   parameter int STEP    = 1,
   localparam int AW     = (N_TIROS > 1) ? $clog2(N_TIROS) : 1
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                iniciar,
   uc_move_tiros_n_if.master   mem,
   output logic                busy,
   output logic                movimentacao_concluida_tiro,
   output logic [AW:0]         tiros_removidos,
   output logic [ESTADO_W-1:0] db_estado
);
   estado_t            r_estado;
   estado_t            w_prox_estado;
   logic [AW-1:0]      r_idx;
   logic [AW:0]        r_removidos;
   logic               r_wr_loaded;
   logic [COORD_W-1:0] r_wr_x;
   logic [COORD_W-1:0] r_wr_y;
   logic [COORD_W-1:0] w_new_x;
   logic [COORD_W-1:0] w_new_y;
   logic               w_sai;
   logic               w_last;

   calc_pos_tiro #(
      .COORD_W (COORD_W),
      .X_MIN   (X_MIN),
      .X_MAX   (X_MAX),
      .Y_MIN   (Y_MIN),
      .Y_MAX   (Y_MAX),
      .STEP    (STEP)
   ) u_calc (
      .i_opcode   (mem.mem_rd_opcode),
      .i_x        (mem.mem_rd_x),
      .i_y        (mem.mem_rd_y),
      .o_new_x    (w_new_x),
      .o_new_y    (w_new_y),
      .o_sai_tela (w_sai)
   );

   assign w_last = (r_idx == AW'(N_TIROS - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_estado <= ST_ESPERA;
      else          r_estado <= w_prox_estado;
   end

   always_comb begin
      w_prox_estado = r_estado;
      case (r_estado)
         ST_ESPERA:   if (iniciar) w_prox_estado = ST_LEITURA;
         ST_LEITURA:  w_prox_estado = ST_AVALIA;
         ST_AVALIA: begin
            if (mem.mem_rd_loaded) w_prox_estado = ST_ESCREVE;
            else if (w_last)       w_prox_estado = ST_SINALIZA;
            else                   w_prox_estado = ST_LEITURA;
         end
         ST_ESCREVE:  w_prox_estado = w_last ? ST_SINALIZA : ST_LEITURA;
         ST_SINALIZA: w_prox_estado = ST_ESPERA;
         default:     w_prox_estado = ST_ESPERA;
      endcase
   end

   // Write data is captured in AVALIA so ESCREVE does not depend on the read port.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_idx       <= '0;
         r_removidos <= '0;
         r_wr_loaded <= 1'b0;
         r_wr_x      <= '0;
         r_wr_y      <= '0;
      end else begin
         case (r_estado)
            ST_ESPERA: begin
               if (iniciar) begin
                  r_idx       <= '0;
                  r_removidos <= '0;
               end
            end
            ST_AVALIA: begin
               if (mem.mem_rd_loaded) begin
                  r_wr_loaded <= ~w_sai;
                  r_wr_x      <= w_sai ? mem.mem_rd_x : w_new_x;
                  r_wr_y      <= w_sai ? mem.mem_rd_y : w_new_y;
               end else if (!w_last) begin
                  r_idx <= r_idx + AW'(1);
               end
            end
            ST_ESCREVE: begin
               if (!r_wr_loaded) r_removidos <= r_removidos + (AW+1)'(1);
               if (!w_last)      r_idx       <= r_idx + AW'(1);
            end
            default: ;
         endcase
      end
   end

   assign mem.mem_addr      = r_idx;
   assign mem.mem_we        = (r_estado == ST_ESCREVE);
   assign mem.mem_wr_loaded = (r_estado == ST_ESCREVE) ? r_wr_loaded : 1'b0;
   assign mem.mem_wr_x      = (r_estado == ST_ESCREVE) ? r_wr_x : '0;
   assign mem.mem_wr_y      = (r_estado == ST_ESCREVE) ? r_wr_y : '0;

   assign busy                        = (r_estado != ST_ESPERA);
   assign movimentacao_concluida_tiro = (r_estado == ST_SINALIZA);
   assign tiros_removidos             = r_removidos;
   assign db_estado                   = r_estado;

endmodule
